battle_round_ctrl: RTL

//  Parametrised turn-based boss-battle controller for the LED-matrix tick game. Runs NUM_LEVELS

---
 rtl/battle_round_ctrl_if.sv | 21 ++
 rtl/battle_round_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/battle_round_ctrl_if.sv
// Handshake between the boss-battle controller and the external click counter.
// The master side (controller) arms the counter; the slave side reports the window result.
interface battle_round_ctrl_if #(
  parameter int CLICK_W = 8
) ();
  logic               fire;
  logic [CLICK_W-1:0] click_count;
  logic               count_done;
  logic               count_start;
  logic               count_enable;

  modport master (
    input  fire, click_count, count_done,
    output count_start, count_enable
  );

  modport slave (
    output fire, click_count, count_done,
    input  count_start, count_enable
  );
endinterface

// File: rtl/battle_round_ctrl.sv
// Turn-based boss-battle controller: fire -> click window -> damage tier -> animations -> HP update.
// Boss HP and boss damage scale with level; win/lose are absorbing until reset.
module battle_round_ctrl #(
  parameter int NUM_LEVELS   = 5,
  parameter int HP_W         = 8,
  parameter int CLICK_W      = 8,
  parameter int BOSS_HP_BASE = 8,
  parameter int BOSS_HP_STEP = 4,
  parameter int PLAYER_HP    = 4,
  parameter int ANIM_CYCLES  = 500,
  parameter int T1 = 10,
  parameter int T2 = 20,
  parameter int T3 = 25,
  parameter int T4 = 35,
  parameter int D1 = 2,
  parameter int D2 = 5,
  parameter int D3 = 10,
  parameter int D4 = 15,
  parameter int D5 = 40
) (
  input  logic                clk,
  input  logic                reset,
  battle_round_ctrl_if.master cnt,
  output logic [3:0]          level,
  output logic [HP_W-1:0]     boss_hp,
  output logic [HP_W-1:0]     player_hp,
  output logic [2:0]          boss_bar,
  output logic [2:0]          player_bar,
  output logic [2:0]          anim_code,
  output logic                win,
  output logic                lose
);
  localparam int TMR_W = (ANIM_CYCLES > 1) ? $clog2(ANIM_CYCLES) : 1;
  localparam int WW    = HP_W + 3;

  typedef enum logic [3:0] {
    S_LOAD, S_IDLE, S_COUNT, S_SELECT, S_ANIM_P,
    S_BOSS_CHK, S_ANIM_B, S_PLAYER_CHK, S_WIN, S_LOSE
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         level_q, level_d;
  logic [HP_W-1:0]    boss_hp_q, boss_hp_d;
  logic [HP_W-1:0]    player_hp_q, player_hp_d;
  logic [HP_W-1:0]    dmg_q, dmg_d;
  logic [CLICK_W-1:0] clicks_q, clicks_d;
  logic [2:0]         anim_q, anim_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               count_start_q, count_start_d;
  logic               count_enable_q, count_enable_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;
  logic               timer_last;
  logic [HP_W-1:0]    boss_max;
  logic [HP_W-1:0]    bdmg;

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a, input logic [HP_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  function automatic logic [HP_W-1:0] level_max(input logic [3:0] lvl);
    logic [WW-1:0] w;
    w = WW'(BOSS_HP_BASE) + WW'(lvl - 4'd1) * WW'(BOSS_HP_STEP);
    return w[HP_W-1:0];
  endfunction

  // Bar segment k lights when hp exceeds (k-1)/4 of max, so any nonzero hp shows at least one.
  function automatic logic [2:0] hp_bar(input logic [HP_W-1:0] hp, input logic [HP_W-1:0] mx);
    logic [WW-1:0] hp4;
    logic [WW-1:0] mxw;
    logic [2:0]    b;
    hp4 = {1'b0, hp, 2'b00};
    mxw = {3'b000, mx};
    b   = 3'd0;
    for (int k = 0; k < 4; k++) begin
      if (hp4 > WW'(k) * mxw) b = b + 3'd1;
    end
    return b;
  endfunction

  assign timer_last = (timer_q == TMR_W'(ANIM_CYCLES - 1));
  assign boss_max   = level_max(level_q);
  assign bdmg       = HP_W'(1) + HP_W'((level_q - 4'd1) >> 1);

  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    boss_hp_d      = boss_hp_q;
    player_hp_d    = player_hp_q;
    dmg_d          = dmg_q;
    clicks_d       = clicks_q;
    anim_d         = anim_q;
    timer_d        = timer_q;
    count_start_d  = 1'b0;
    count_enable_d = count_enable_q;
    win_d          = win_q;
    lose_d         = lose_q;
    unique case (state_q)
      S_LOAD: begin
        boss_hp_d   = boss_max;
        player_hp_d = HP_W'(PLAYER_HP);
        anim_d      = 3'd0;
        state_d     = S_IDLE;
      end
      S_IDLE: begin
        anim_d = 3'd0;
        if (cnt.fire) begin
          count_start_d  = 1'b1;
          count_enable_d = 1'b1;
          state_d        = S_COUNT;
        end
      end
      S_COUNT: begin
        if (cnt.count_done) begin
          clicks_d       = cnt.click_count;
          count_enable_d = 1'b0;
          state_d        = S_SELECT;
        end
      end
      S_SELECT: begin
        timer_d = '0;
        state_d = S_ANIM_P;
        if (clicks_q == '0) begin
          dmg_d  = '0;
          anim_d = 3'd6;
        end else if (clicks_q <= CLICK_W'(T1)) begin
          dmg_d  = HP_W'(D1);
          anim_d = 3'd1;
        end else if (clicks_q <= CLICK_W'(T2)) begin
          dmg_d  = HP_W'(D2);
          anim_d = 3'd2;
        end else if (clicks_q <= CLICK_W'(T3)) begin
          dmg_d  = HP_W'(D3);
          anim_d = 3'd3;
        end else if (clicks_q <= CLICK_W'(T4)) begin
          dmg_d  = HP_W'(D4);
          anim_d = 3'd4;
        end else begin
          dmg_d  = HP_W'(D5);
          anim_d = 3'd5;
        end
      end
      S_ANIM_P: begin
        if (timer_last) begin
          timer_d = '0;
          anim_d  = 3'd0;
          state_d = S_BOSS_CHK;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_BOSS_CHK: begin
        boss_hp_d = sat_sub(boss_hp_q, dmg_q);
        if (boss_hp_d == '0) begin
          if (level_q == 4'(NUM_LEVELS)) begin
            win_d   = 1'b1;
            state_d = S_WIN;
          end else begin
            level_d = level_q + 4'd1;
            state_d = S_LOAD;
          end
        end else begin
          anim_d  = 3'd7;
          timer_d = '0;
          state_d = S_ANIM_B;
        end
      end
      S_ANIM_B: begin
        if (timer_last) begin
          timer_d = '0;
          anim_d  = 3'd0;
          state_d = S_PLAYER_CHK;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_PLAYER_CHK: begin
        player_hp_d = sat_sub(player_hp_q, bdmg);
        if (player_hp_d == '0) begin
          lose_d  = 1'b1;
          state_d = S_LOSE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WIN, S_LOSE: begin
        anim_d = 3'd0;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_LOAD;
      level_q        <= 4'd1;
      boss_hp_q      <= '0;
      player_hp_q    <= '0;
      dmg_q          <= '0;
      clicks_q       <= '0;
      anim_q         <= 3'd0;
      timer_q        <= '0;
      count_start_q  <= 1'b0;
      count_enable_q <= 1'b0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      boss_hp_q      <= boss_hp_d;
      player_hp_q    <= player_hp_d;
      dmg_q          <= dmg_d;
      clicks_q       <= clicks_d;
      anim_q         <= anim_d;
      timer_q        <= timer_d;
      count_start_q  <= count_start_d;
      count_enable_q <= count_enable_d;
      win_q          <= win_d;
      lose_q         <= lose_d;
    end
  end

  assign cnt.count_start  = count_start_q;
  assign cnt.count_enable = count_enable_q;
  assign level            = level_q;
  assign boss_hp          = boss_hp_q;
  assign player_hp        = player_hp_q;
  assign anim_code        = anim_q;
  assign win              = win_q;
  assign lose             = lose_q;
  assign boss_bar         = hp_bar(boss_hp_q, boss_max);
  assign player_bar       = hp_bar(player_hp_q, HP_W'(PLAYER_HP));
endmodule
